// File: rtl/io_bank_pkg.sv
// io_bank_pkg: shared constants for the parametrised edge IO bank.
//   CFG_W          width of one channel's config byte
//   CFG_*          bit positions inside a channel config byte
//   nframes()      number of frame words needed to hold nch config bytes
package io_bank_pkg;

    localparam int CFG_W = 8;

    localparam int CFG_I_REG   = 0;  // O taken from the registered path
    localparam int CFG_SYNC2   = 1;  // two-flop synchroniser on O_top
    localparam int CFG_O_REG   = 2;  // register I_top
    localparam int CFG_T_REG   = 3;  // register T_top
    localparam int CFG_O_INV   = 4;  // invert fabric data towards the pad
    localparam int CFG_T_INV   = 5;  // invert fabric tristate towards the pad
    localparam int CFG_FILT_EN = 6;  // glitch filter on the input path
    localparam int CFG_CH_EN   = 7;  // channel enable

    function automatic int nframes(input int nch, input int fbits);
        return (nch * CFG_W + fbits - 1) / fbits;
    endfunction

endpackage

// File: rtl/io_bank_channel.sv
// io_bank_channel: one bidirectional pad channel.
//   UserCLK, Reset   clock and asynchronous active-high reset
//   cfg              this channel's config byte (see io_bank_pkg bit map)
//   I, T             fabric data / tristate towards the pad
//   O_top            pad input value
//   O                pad-to-fabric data, combinational or registered
//   Q                pad-to-fabric data, always registered
//   I_top, T_top     pad output value / tristate (1 = high-Z)
module io_bank_channel
    import io_bank_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic             UserCLK,
    input  logic             Reset,
    input  logic [CFG_W-1:0] cfg,
    input  logic             I,
    input  logic             T,
    input  logic             O_top,
    output logic             O,
    output logic             Q,
    output logic             I_top,
    output logic             T_top
);

    localparam int CNT_W = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic             ch_en;
    logic             filt_en;
    logic             sync_1;
    logic             sync_2;
    logic             s;
    logic             f;
    logic             filt_q;
    logic [CNT_W-1:0] cnt;
    logic             q_r;
    logic             ov_q;
    logic             tv_q;

    assign ch_en   = cfg[CFG_CH_EN];
    assign filt_en = cfg[CFG_FILT_EN];
    assign s       = cfg[CFG_SYNC2] ? sync_2 : O_top;
    assign f       = filt_en ? filt_q : s;

    // A disabled channel holds every flop at its reset value, so
    // re-enabling it always starts from a known state.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            filt_q <= 1'b0;
            cnt    <= '0;
            q_r    <= 1'b0;
            ov_q   <= 1'b0;
            tv_q   <= 1'b0;
        end else if (!ch_en) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            filt_q <= 1'b0;
            cnt    <= '0;
            q_r    <= 1'b0;
            ov_q   <= 1'b0;
            tv_q   <= 1'b0;
        end else begin
            sync_1 <= O_top;
            sync_2 <= sync_1;
            // With the filter off, filt_q tracks s so that turning the
            // filter on never releases a stale level.
            if (!filt_en) begin
                filt_q <= s;
                cnt    <= '0;
            end else if (s == filt_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt_q <= s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            q_r  <= f;
            ov_q <= I ^ cfg[CFG_O_INV];
            tv_q <= T ^ cfg[CFG_T_INV];
        end
    end

    assign Q     = q_r;
    assign O     = ch_en & (cfg[CFG_I_REG] ? q_r : f);
    assign I_top = ch_en & (cfg[CFG_O_REG] ? ov_q : (I ^ cfg[CFG_O_INV]));
    assign T_top = ~ch_en | (cfg[CFG_T_REG] ? tv_q : (T ^ cfg[CFG_T_INV]));

endmodule

// File: rtl/io_bank_nch.sv
// io_bank_nch: NCH-channel bidirectional IO bank between the tile switch
// matrix and the pads, configured through the FrameData/FrameStrobe bus.
//   UserCLK, Reset        clock and asynchronous active-high reset
//   I, T                  fabric data / tristate (1 = high-Z), per channel
//   O, Q                  pad-to-fabric data (configurable / registered)
//   O_top                 pad input values
//   I_top, T_top          pad output values / tristates
//   FrameData             config write data word
//   FrameStrobe           per-frame write select
//   ConfigBits            readback of all channel config bytes
module io_bank_nch
    import io_bank_pkg::*;
#(
    parameter int NCH             = 4,
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int FILT_LEN        = 4
) (
    input  logic                       UserCLK,
    input  logic                       Reset,
    input  logic [NCH-1:0]             I,
    input  logic [NCH-1:0]             T,
    output logic [NCH-1:0]             O,
    output logic [NCH-1:0]             Q,
    input  logic [NCH-1:0]             O_top,
    output logic [NCH-1:0]             I_top,
    output logic [NCH-1:0]             T_top,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [NCH*CFG_W-1:0]       ConfigBits
);

    localparam int CFG_BITS = NCH * CFG_W;
    localparam int NFRAMES  = nframes(NCH, FrameBitsPerRow);

    logic [CFG_BITS-1:0] cfg_q;
    logic [CFG_BITS-1:0] cfg_d;
    logic                unused_frame_bits;

    // Each stored config bit belongs to exactly one frame word; bits of the
    // last word beyond CFG_BITS and strobes at or above NFRAMES have no
    // destination and simply drop out.
    always_comb begin
        cfg_d = cfg_q;
        for (int b = 0; b < CFG_BITS; b++) begin
            if (FrameStrobe[b / FrameBitsPerRow]) begin
                cfg_d[b] = FrameData[b % FrameBitsPerRow];
            end
        end
    end

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    // Frame bus bits that some parameterisations never consume.
    assign unused_frame_bits = ^{FrameStrobe, FrameData, NFRAMES[0]};

    assign ConfigBits = cfg_q;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        io_bank_channel #(
            .FILT_LEN(FILT_LEN)
        ) u_ch (
            .UserCLK (UserCLK),
            .Reset   (Reset),
            .cfg     (cfg_q[n*CFG_W +: CFG_W]),
            .I       (I[n]),
            .T       (T[n]),
            .O_top   (O_top[n]),
            .O       (O[n]),
            .Q       (Q[n]),
            .I_top   (I_top[n]),
            .T_top   (T_top[n])
        );
    end

endmodule

// File: doc/io_bank_nch.md
Name: io_bank_nch

Overview:
- Parametrised successor to the fixed 4-channel bidirectional IO BEL group used in the edge IO tiles.
- Provides NCH pad channels, each with its own 8-bit config byte.
- Per-channel features: optional input synchroniser, glitch filter, registered or combinational input/output/tristate paths, and output/tristate inversion.
- Config bytes are loaded synchronously from the tile's FrameData/FrameStrobe frame bus. The block sits between the tile switch matrix (fabric side) and the top-level pads.

Parameters:
- NCH, 4, number of IO channels (1..16)
- FrameBitsPerRow, 32, FrameData width
- MaxFramesPerCol, 20, FrameStrobe width
- FILT_LEN, 4, consecutive stable cycles required by the glitch filter (>=1)
- Constraint: NCH*8 <= FrameBitsPerRow*MaxFramesPerCol
- Derived: NFRAMES = ceil(NCH*8/FrameBitsPerRow)

Ports:
- UserCLK  in  1  fabric user clock; sole clock
- Reset  in  1  asynchronous, active-high reset
- I  in  NCH  fabric-to-pad data
- T  in  NCH  fabric tristate control (1 = high-Z)
- O  out  NCH  pad-to-fabric data, combinational or registered per config
- Q  out  NCH  pad-to-fabric data, always registered
- O_top  in  NCH  pad input value
- I_top  out  NCH  pad output value
- T_top  out  NCH  pad tristate (1 = high-Z)
- FrameData  in  FrameBitsPerRow  config write data
- FrameStrobe  in  MaxFramesPerCol  one-hot-ish frame write select
- ConfigBits  out  NCH*8  readback of the config register

Behaviour:
- Config byte c for channel n = cfg[n*8 +: 8]. Bit fields:
  - 0 I_REG: O sourced from registered path
  - 1 SYNC2: two-flop synchroniser on O_top
  - 2 O_REG: register I_top
  - 3 T_REG: register T_top
  - 4 O_INV
  - 5 T_INV
  - 6 FILT_EN
  - 7 CH_EN
- Config write:
  - On each UserCLK rising edge, for every k < NFRAMES with FrameStrobe[k]=1: cfg[k*FrameBitsPerRow +: FrameBitsPerRow] <= FrameData.
  - Bits above NCH*8 are discarded. FrameStrobe[k] for k >= NFRAMES is ignored.
  - If several strobes are high at once, all selected words are written with the same data.
  - A new config is visible on ConfigBits and takes effect on the datapath from the cycle after the write edge.
- Reset:
  - cfg=0, all flops=0, filter counters=0.
  - Outputs during and after reset: I_top=0, T_top=1, O=0, Q=0, ConfigBits=0.
- Channel disabled (CH_EN=0):
  - I_top=0, T_top=1, O=0, Q=0.
  - Sync, filter and output flops are held at their reset values.
  - Disabling a channel mid-operation forces T_top=1 within 1 cycle of the write edge.
- Input path, per enabled channel:
  - s = SYNC2 ? sync2(O_top) : O_top, with 2 cycles added when SYNC2=1.
  - f = FILT_EN ? filt(s) : s.
  - Q <= f every cycle.
  - O = I_REG ? Q : f.
- Glitch filter, per channel: state filt_q, counter cnt of clog2(FILT_LEN+1) bits.
  - s == filt_q: cnt <= 0.
  - s != filt_q and cnt == FILT_LEN-1: filt_q <= s, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Result: a change propagates only after FILT_LEN consecutive differing cycles; a shorter pulse is discarded and the counter restarts.
  - Clearing FILT_EN resets cnt to 0 and loads filt_q <= s.
- Output path:
  - ov = I ^ O_INV; tv = T ^ T_INV.
  - I_top = O_REG ? ov_q : ov.
  - T_top = T_REG ? tv_q : tv.
  - Registered variants have 1-cycle latency; ov_q and tv_q update every cycle regardless of the select bits.
- Latency from O_top to Q: 1 cycle, plus 2 with SYNC2, plus FILT_LEN with the filter.
- Reset asserted mid-operation takes effect immediately (asynchronous). After deassertion, all channels stay disabled until reconfigured.

Decomposition:
- Package io_bank_pkg:
  - CFG_W=8
  - bit index constants CFG_I_REG … CFG_CH_EN
  - function nframes(nch, fbits)
- Sub-module io_bank_channel: one channel's sync, filter and output flops. Parameter FILT_LEN; inputs are its config byte, UserCLK and Reset.
- Top level io_bank_nch contains:
  - the frame-write config register
  - a generate loop of NCH io_bank_channel instances

Test Plan:
1. Reset then idle, NCH=4 → T_top=4'hF, I_top=0, O=0, Q=0, ConfigBits=0.
2. FrameStrobe[0]=1 with FrameData=32'h80808080 (all channels CH_EN, combinational), I=4'b1010, T=0 → same cycle I_top=4'b1010, T_top=0; O_top=4'b0110 gives O=4'b0110 and Q=4'b0110 one cycle later.
3. Channel 0 cfg=8'h9C (CH_EN, O_REG, T_REG, O_INV), I[0]=0 → I_top[0]=1 appears exactly 1 edge after I changes; T_top[0] follows T with 1 cycle delay.
4. Channel 1 cfg=8'hC0 (filter on), FILT_LEN=4, O_top[1] pulses high for 3 cycles → Q[1] stays 0. A 4-cycle-high pulse → Q[1] rises 5 edges after O_top rises (4 filter + 1 register).
5. Channel 2 cfg=8'h83 (SYNC2, I_REG) → O_top edge reaches O[2] and Q[2] after 3 edges. Then write cfg=8'h00 → T_top[2]=1 and O[2]=0 on the next cycle.
6. NCH=5, FrameStrobe=2'b11 with FrameData=32'hFFFFFFFF → ConfigBits = 40'hFF_FFFFFFFF, upper word bits discarded. Reset asserted mid-test → all outputs return to reset values without a clock edge.
